// File: rtl/logic_unit_scheduler_if.sv
// Request/response bundle between the issuing front-end (master) and the
// logic unit scheduler (slave).
interface logic_unit_scheduler_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]     req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         result;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, result
  );
endinterface

// File: rtl/logic_unit_scheduler.sv
// Round-robin arbiter in front of a shared bitwise logic datapath
// (AND/OR/XOR/NAND); one operation in flight, tagged response.
module logic_unit_scheduler #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  logic_unit_scheduler_if.slave       bus,
  output logic                        busy,
  output logic [7:0]                  done_count
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic             any_valid;
  logic             accept;
  logic             rsp_done;

  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [1:0]       op_q;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // First valid requester at or after ptr, wrapping past NUM_REQ-1.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a path that skips the assignment infers a latch.
    winner    = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx[IDW-1:0];
      end
    end
  end

  assign accept   = (state == IDLE) && any_valid;
  assign rsp_done = (state == RESP) && bus.rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; the grant is masked by rst_n so it drops the moment reset asserts.
  always_comb begin
    bus.req_ready = '0;
    if (accept && rst_n) bus.req_ready[winner] = 1'b1;
    bus.rsp_valid = (state == RESP);
    busy          = (state != IDLE);
  end

  // Captured operation, shared datapath result, rotation pointer and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      ptr        <= '0;
      done_count <= '0;
    end else begin
      if (accept) begin
        id_q <= winner;
        a_q  <= bus.req_a[winner*WIDTH +: WIDTH];
        b_q  <= bus.req_b[winner*WIDTH +: WIDTH];
        op_q <= bus.req_op[winner*2 +: 2];
      end
      if (state == EXEC) result_q <= logic_op(a_q, b_q, op_q);
      if (rsp_done) begin
        ptr        <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        done_count <= done_count + 8'd1;
      end
    end
  end

  assign bus.rsp_id = id_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler: reset, opcodes, rotation,
// pointer skip, backpressure and counter wrap.
module tb_logic_unit_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] done_count;
  int         total = 0;
  int         bad   = 0;

  logic_unit_scheduler_if #(.WIDTH(4), .NUM_REQ(4)) bus ();

  logic_unit_scheduler #(.WIDTH(4), .NUM_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
    bus.req_op[i*2 +: 2] = op;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, then samples the two following cycles.
  // Called just after a negedge; returns at the RESP-cycle negedge.
  task automatic do_op(input bit pulse2, output int gid, output int waits,
                       output logic rv1, output logic rv2,
                       output logic [3:0] res, output int rid);
    gid = -1; waits = 0; rv1 = 1'b0; rv2 = 1'b0; res = 4'h0; rid = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.req_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gid = i;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (gid < 0) return;
    @(negedge clk);
    rv1 = bus.rsp_valid;
    if (pulse2) bus.req_valid[2] = 1'b1;
    @(negedge clk);
    rv2 = bus.rsp_valid;
    res = bus.result;
    rid = int'(bus.rsp_id);
    if (pulse2) bus.req_valid[2] = 1'b0;
  endtask

  task automatic test_reset();
    int gid, waits, rid;
    logic rv1, rv2;
    logic [3:0] res;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, busy, done_count} !== {4'b0000, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_initial: ready/valid/busy/count=%b/%b/%b/%0d want 0000/0/0/0",
               bus.req_ready, bus.rsp_valid, busy, done_count);
    end
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);

    set_req(3, 4'b1111, 4'b0101, 2'b01);
    bus.req_valid = 4'b1000;
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    bus.req_valid = 4'b0000;
    total++;
    if (gid !== 3 || rid !== 3 || res !== 4'b1111) begin
      bad++;
      $display("FAIL reset_pre_op: gid=%0d rid=%0d res=%b want 3 3 1111", gid, rid, res);
    end
    @(negedge clk);

    // Start an operation for requester 1, then reset while it is in EXEC.
    set_req(1, 4'b0110, 4'b0011, 2'b10);
    bus.req_valid = 4'b0010;
    #1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_exec_state: busy=%b rsp_valid=%b want 1 0", busy, bus.rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.result, busy, done_count} !==
        {4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_async: ready=%b valid=%b id=%0d res=%b busy=%b count=%0d want all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.result, busy, done_count);
    end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_discard: cycle %0d rsp_valid=%b busy=%b want 0 0", c, bus.rsp_valid, busy);
      end
    end

    set_req(2, 4'b1100, 4'b1010, 2'b00);
    bus.req_valid = 4'b0100;
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    bus.req_valid = 4'b0000;
    total++;
    if (gid !== 2 || rid !== 2 || res !== 4'b1000) begin
      bad++;
      $display("FAIL reset_after_op: gid=%0d rid=%0d res=%b want 2 2 1000", gid, rid, res);
    end
    total++;
    if (rv1 !== 1'b0 || rv2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_latency: rsp_valid one edge=%b two edges=%b want 0 1", rv1, rv2);
    end
    @(negedge clk);
  endtask

  task automatic test_opcode_sweep();
    int gid, waits, rid;
    logic rv1, rv2;
    logic [3:0] res;
    logic [3:0] exp_res [4];
    exp_res = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
    bus.rsp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      set_req(0, 4'b1100, 4'b1010, op[1:0]);
      bus.req_valid = 4'b0001;
      do_op(1'b0, gid, waits, rv1, rv2, res, rid);
      bus.req_valid = 4'b0000;
      total++;
      if (gid !== 0 || rid !== 0 || res !== exp_res[op]) begin
        bad++;
        $display("FAIL opcode_%0d: gid=%0d rid=%0d res=%b want 0 0 %b", op, gid, rid, res, exp_res[op]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int gid, waits, rid;
    logic rv1, rv2;
    logic [3:0] res;
    logic [3:0] exp_res [4];
    exp_res = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'b1100, 4'b1010, 2'(i));
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      do_op(1'b0, gid, waits, rv1, rv2, res, rid);
      total++;
      if (gid !== k % 4 || rid !== k % 4 || res !== exp_res[k % 4]) begin
        bad++;
        $display("FAIL rr_op_%0d: gid=%0d rid=%0d res=%b want %0d %0d %b",
                 k, gid, rid, res, k % 4, k % 4, exp_res[k % 4]);
      end
      if (k > 0) begin
        total++;
        if (waits !== 1) begin
          bad++;
          $display("FAIL rr_spacing_%0d: idle cycles before accept=%0d want 1", k, waits);
        end
      end
    end
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (done_count !== 8'd8) begin
      bad++;
      $display("FAIL rr_done_count: got %0d want 8", done_count);
    end
  endtask

  task automatic test_pointer_skip();
    int gid, waits, rid;
    logic rv1, rv2;
    logic [3:0] res;
    set_req(0, 4'b0001, 4'b0001, 2'b01);
    set_req(1, 4'b1010, 4'b0110, 2'b10);
    set_req(3, 4'b0011, 4'b1001, 2'b00);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    bus.req_valid = 4'b0001;
    total++;
    if (gid !== 1 || res !== 4'b1100) begin
      bad++;
      $display("FAIL skip_first: gid=%0d res=%b want 1 1100", gid, res);
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL skip_hold: req_ready=%b rsp_valid=%b want 0000 1", bus.req_ready, bus.rsp_valid);
    end
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 1'b1;
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    bus.req_valid = 4'b0001;
    total++;
    if (gid !== 3 || rid !== 3 || res !== 4'b0001) begin
      bad++;
      $display("FAIL skip_to_3: gid=%0d rid=%0d res=%b want 3 3 0001", gid, rid, res);
    end
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    bus.req_valid = 4'b0000;
    total++;
    if (gid !== 0 || rid !== 0 || res !== 4'b0001) begin
      bad++;
      $display("FAIL skip_wrap_0: gid=%0d rid=%0d res=%b want 0 0 0001", gid, rid, res);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int gid, waits, rid;
    logic rv1, rv2;
    logic [3:0] res;
    set_req(1, 4'b1001, 4'b1100, 2'b00);
    set_req(2, 4'b0101, 4'b0011, 2'b11);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    total++;
    if (gid !== 1 || rid !== 1 || res !== 4'b1000) begin
      bad++;
      $display("FAIL bp_grant: gid=%0d rid=%0d res=%b want 1 1 1000", gid, rid, res);
    end
    // Operands changed after accept must not reach the result.
    set_req(1, 4'b0000, 4'b0000, 2'b11);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.result} !==
          {1'b1, 4'b0000, 2'd1, 4'b1000}) begin
        bad++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b id=%0d res=%b want 1 0000 1 1000",
                 c, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.result);
      end
    end
    bus.rsp_ready = 1'b1;
    do_op(1'b0, gid, waits, rv1, rv2, res, rid);
    bus.req_valid = 4'b0000;
    total++;
    if (gid !== 2 || rid !== 2 || res !== 4'b1110) begin
      bad++;
      $display("FAIL bp_release: gid=%0d rid=%0d res=%b want 2 2 1110", gid, rid, res);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int gid, waits, rid;
    int exp_id [3];
    logic rv1, rv2;
    logic [3:0] res;
    logic [3:0] exp_res [3];
    exp_id  = '{0, 1, 3};
    exp_res = '{4'b0110, 4'b0111, 4'b1110};
    apply_reset();
    set_req(0, 4'b0011, 4'b0101, 2'b10);
    set_req(1, 4'b0011, 4'b0101, 2'b01);
    set_req(2, 4'b1111, 4'b1111, 2'b00);
    set_req(3, 4'b0011, 4'b0101, 2'b11);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1011;
    for (int k = 0; k < 257; k++) begin
      do_op(1'b1, gid, waits, rv1, rv2, res, rid);
      total++;
      if (gid !== exp_id[k % 3] || rid !== exp_id[k % 3] || res !== exp_res[k % 3]) begin
        bad++;
        $display("FAIL wrap_op_%0d: gid=%0d rid=%0d res=%b want %0d %0d %b",
                 k, gid, rid, res, exp_id[k % 3], exp_id[k % 3], exp_res[k % 3]);
      end
      if (gid < 0) break;
    end
    bus.req_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (done_count !== 8'd1) begin
      bad++;
      $display("FAIL wrap_done_count: got %0d want 1", done_count);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    test_reset();
    test_opcode_sweep();
    test_round_robin();
    test_pointer_skip();
    test_backpressure();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
